hazard_scoreboard: RTL and testbench

- Issue controller between decode and execute in the RV32I pipeline.
- Keeps a per-register in-flight write count: incremented when an instruction that writes rd leaves decode, decremented when writeback writes that register.
- Stalls decode on RAW hazards against the register file.
- Sequences redirect flushes and a drain-to-empty handshake used for halt/ecall.

---
 rtl/hazard_scoreboard.sv | 173 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode/execute issue controller: per-register in-flight write counters, RAW stall,
// redirect flush sequencing and drain handshake. Optional stats under HAZARD_STATS_EN.
module hazard_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int RF_BYPASS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_id_valid,
    input  logic [4:0] i_rs1_raddr,
    input  logic [4:0] i_rs2_raddr,
    input  logic [4:0] i_rd,
    input  logic       i_reg_write,
    input  logic       i_wb_valid,
    input  logic [4:0] i_wb_waddr,
    input  logic       i_redirect,
    input  logic       i_drain_req,
    output logic       o_stall,
    output logic       o_issue,
    output logic       o_flush,
    output logic       o_drained,
    output logic       o_busy,
    output logic [1:0] o_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_cycles
`endif
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic             BYPASS  = (RF_BYPASS != 0);

    logic [1:0]             r_state;
    logic [FC_W-1:0]        r_fcnt;
    logic [31:0][CNT_W-1:0] r_cnt;

    logic [1:0]             w_state_nxt;
    logic [FC_W-1:0]        w_fcnt_nxt;
    logic [31:0][CNT_W-1:0] w_cnt_nxt;
    logic [31:0]            w_busy;
    logic                   w_hz;
    logic                   w_rd_sat;
    logic                   w_inc_en;
    logic                   w_all_clear;
    logic                   w_stall;
    logic                   w_issue;
    logic                   w_flush;
    logic                   w_drained;

    assign w_inc_en = w_issue && i_reg_write;

    // x0 is hardwired untracked; every other register gets its own counter slice
    for (genvar g = 0; g < 32; g++) begin : g_reg
        if (g == 0) begin : g_x0
            assign w_busy[g]    = 1'b0;
            assign w_cnt_nxt[g] = '0;
        end else begin : g_trk
            logic w_inc;
            logic w_dec;
            logic w_wb_hit;
            assign w_wb_hit     = i_wb_valid && (i_wb_waddr == 5'(g));
            assign w_inc        = w_inc_en && (i_rd == 5'(g)) && (r_cnt[g] != CNT_MAX);
            assign w_dec        = w_wb_hit && (r_cnt[g] != '0);
            assign w_busy[g]    = (r_cnt[g] != '0) &&
                                  !(BYPASS && w_wb_hit && (r_cnt[g] == CNT_ONE));
            assign w_cnt_nxt[g] = (w_inc && !w_dec) ? r_cnt[g] + CNT_ONE :
                                  (w_dec && !w_inc) ? r_cnt[g] - CNT_ONE : r_cnt[g];
        end
    end

    assign w_rd_sat    = i_reg_write && (i_rd != 5'd0) && (r_cnt[i_rd] == CNT_MAX);
    assign w_hz        = i_id_valid && (w_busy[i_rs1_raddr] || w_busy[i_rs2_raddr] || w_rd_sat);
    // only evaluated in DRAIN, where nothing issues, so next counts carry just the wb decrements
    assign w_all_clear = (w_cnt_nxt == '0);

    always_comb begin
        w_stall     = 1'b0;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        w_drained   = 1'b0;
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_RUN: begin
                w_stall = w_hz;
                w_issue = i_id_valid && !w_hz && !i_redirect;
                w_flush = i_redirect;
                if (i_redirect) begin
                    w_fcnt_nxt  = FC_LOAD;
                    w_state_nxt = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
                end else if (i_drain_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                if (i_redirect) begin
                    w_fcnt_nxt  = FC_LOAD;
                    w_state_nxt = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
                end else if (r_fcnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - FC_W'(1);
                end
            end
            ST_DRAIN: begin
                w_stall   = 1'b1;
                w_flush   = i_redirect;
                w_drained = w_all_clear;
                if (i_redirect) begin
                    w_fcnt_nxt  = FC_LOAD;
                    w_state_nxt = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
                end else if (!i_drain_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
        if (i_rst) begin
            w_stall   = 1'b0;
            w_issue   = 1'b0;
            w_flush   = 1'b0;
            w_drained = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_stall   = w_stall;
    assign o_issue   = w_issue;
    assign o_flush   = w_flush;
    assign o_drained = w_drained;
    assign o_busy    = |r_cnt;
    assign o_state   = r_state;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            r_stall_cycles <= r_stall_cycles + 32'(w_stall);
            r_flush_cycles <= r_flush_cycles + 32'(w_flush);
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: per-step expected outputs queued with the stimulus
// and popped when the step's outputs settle. Stats checks compile in with HAZARD_STATS_EN.
module tb_hazard_scoreboard;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_id_valid;
    logic [4:0] i_rs1_raddr;
    logic [4:0] i_rs2_raddr;
    logic [4:0] i_rd;
    logic       i_reg_write;
    logic       i_wb_valid;
    logic [4:0] i_wb_waddr;
    logic       i_redirect;
    logic       i_drain_req;
    logic       o_stall;
    logic       o_issue;
    logic       o_flush;
    logic       o_drained;
    logic       o_busy;
    logic [1:0] o_state;
`ifdef HAZARD_STATS_EN
    logic [31:0] o_stall_cycles;
    logic [31:0] o_flush_cycles;
`endif

    hazard_scoreboard #(.CNT_W(2), .FLUSH_CYCLES(2), .RF_BYPASS(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid),
        .i_rs1_raddr(i_rs1_raddr), .i_rs2_raddr(i_rs2_raddr), .i_rd(i_rd),
        .i_reg_write(i_reg_write), .i_wb_valid(i_wb_valid), .i_wb_waddr(i_wb_waddr),
        .i_redirect(i_redirect), .i_drain_req(i_drain_req),
        .o_stall(o_stall), .o_issue(o_issue), .o_flush(o_flush),
        .o_drained(o_drained), .o_busy(o_busy), .o_state(o_state)
`ifdef HAZARD_STATS_EN
        , .o_stall_cycles(o_stall_cycles), .o_flush_cycles(o_flush_cycles)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       wbv;
        logic [4:0] wba;
        logic       redir;
        logic       drain;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       issue;
        logic       flush;
        logic       drained;
        logic       busy;
        logic [1:0] state;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic stim_t S(int idv, int rs1, int rs2, int rd, int rw,
                                int wbv, int wba, int redir, int drain);
        stim_t s;
        s.idv = 1'(idv); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
        s.rw = 1'(rw); s.wbv = 1'(wbv); s.wba = 5'(wba);
        s.redir = 1'(redir); s.drain = 1'(drain);
        return s;
    endfunction

    function automatic exp_t X(int stall, int issue, int flush, int drained, int busy, int st);
        exp_t e;
        e.stall = 1'(stall); e.issue = 1'(issue); e.flush = 1'(flush);
        e.drained = 1'(drained); e.busy = 1'(busy); e.state = 2'(st);
        return e;
    endfunction

    function automatic exp_t obs();
        return {o_stall, o_issue, o_flush, o_drained, o_busy, o_state};
    endfunction

    task automatic apply(input stim_t s);
        @(negedge i_clk);
        i_id_valid  = s.idv;
        i_rs1_raddr = s.rs1;
        i_rs2_raddr = s.rs2;
        i_rd        = s.rd;
        i_reg_write = s.rw;
        i_wb_valid  = s.wbv;
        i_wb_waddr  = s.wba;
        i_redirect  = s.redir;
        i_drain_req = s.drain;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  e;
        i_rst = 1'b1;
        st.push_back(S(1,5,0,5,1,1,5,1,1)); exp_q.push_back(X(0,0,0,0,0,0));
        st.push_back(S(1,5,0,5,1,0,0,0,1)); exp_q.push_back(X(0,0,0,0,0,0));
        foreach (st[k]) begin
            apply(st[k]); #1;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL reset step %0d: got %b want %b", k, obs(), e); end
        end
        apply(S(0,0,0,0,0,0,0,0,0)); i_rst = 1'b0; exp_q.push_back(X(0,0,0,0,0,0)); #1;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL reset_release: got %b want %b", obs(), e); end
    endtask

    task automatic test_raw();
        stim_t st[$];
        exp_t  e;
`ifdef HAZARD_STATS_EN
        logic [31:0] s0 = o_stall_cycles;
`endif
        st.push_back(S(1,0,0,5,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        for (int i = 0; i < 3; i++) begin
            st.push_back(S(1,5,0,6,0,0,0,0,0)); exp_q.push_back(X(1,0,0,0,1,0));
        end
        st.push_back(S(1,5,0,6,0,1,5,0,0)); exp_q.push_back(X(0,1,0,0,1,0));
        st.push_back(S(1,5,0,6,0,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(0,0,0,0,0,0,0,0,0)); exp_q.push_back(X(0,0,0,0,0,0));
        foreach (st[k]) begin
            apply(st[k]); #1;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL raw step %0d: got %b want %b", k, obs(), e); end
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (o_stall_cycles - s0 !== 32'd3) begin
            failures++; $display("FAIL raw_stall_cycles: got %0d want 3", o_stall_cycles - s0);
        end
`endif
    endtask

    task automatic test_x0_saturation();
        stim_t st[$];
        exp_t  e;
        st.push_back(S(1,0,0,0,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(1,0,0,0,0,1,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(1,0,0,7,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(1,0,0,7,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,1,0));
        st.push_back(S(1,0,0,7,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,1,0));
        st.push_back(S(1,0,0,7,1,0,0,0,0)); exp_q.push_back(X(1,0,0,0,1,0));
        for (int i = 0; i < 3; i++) begin
            st.push_back(S(0,0,0,0,0,1,7,0,0)); exp_q.push_back(X(0,0,0,0,1,0));
        end
        st.push_back(S(0,0,0,0,0,1,7,0,0)); exp_q.push_back(X(0,0,0,0,0,0));
        st.push_back(S(0,0,0,0,0,0,0,0,0)); exp_q.push_back(X(0,0,0,0,0,0));
        foreach (st[k]) begin
            apply(st[k]); #1;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL x0_sat step %0d: got %b want %b", k, obs(), e); end
        end
    endtask

    task automatic test_redirect();
        stim_t st[$];
        exp_t  e;
`ifdef HAZARD_STATS_EN
        logic [31:0] f0 = o_flush_cycles;
`endif
        st.push_back(S(1,1,0,2,1,0,0,1,0)); exp_q.push_back(X(0,0,1,0,0,0));
        st.push_back(S(1,1,0,2,1,0,0,0,0)); exp_q.push_back(X(0,0,1,0,0,1));
        st.push_back(S(1,1,0,2,1,0,0,0,0)); exp_q.push_back(X(0,0,1,0,0,1));
        st.push_back(S(1,1,0,2,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(0,0,0,0,0,1,2,0,0)); exp_q.push_back(X(0,0,0,0,1,0));
        foreach (st[k]) begin
            apply(st[k]); #1;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL redirect step %0d: got %b want %b", k, obs(), e); end
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (o_flush_cycles - f0 !== 32'd3) begin
            failures++; $display("FAIL redirect_flush_cycles: got %0d want 3", o_flush_cycles - f0);
        end
`endif
    endtask

    task automatic test_redirect_extend();
        stim_t st[$];
        exp_t  e;
        st.push_back(S(0,0,0,0,0,0,0,1,0)); exp_q.push_back(X(0,0,1,0,0,0));
        st.push_back(S(0,0,0,0,0,0,0,0,0)); exp_q.push_back(X(0,0,1,0,0,1));
        st.push_back(S(0,0,0,0,0,0,0,1,0)); exp_q.push_back(X(0,0,1,0,0,1));
        st.push_back(S(0,0,0,0,0,0,0,0,1)); exp_q.push_back(X(0,0,1,0,0,1));
        st.push_back(S(0,0,0,0,0,0,0,0,1)); exp_q.push_back(X(0,0,1,0,0,1));
        st.push_back(S(0,0,0,0,0,0,0,0,1)); exp_q.push_back(X(0,0,0,0,0,0));
        st.push_back(S(0,0,0,0,0,0,0,0,1)); exp_q.push_back(X(1,0,0,1,0,2));
        st.push_back(S(0,0,0,0,0,0,0,0,0)); exp_q.push_back(X(1,0,0,1,0,2));
        st.push_back(S(0,0,0,0,0,0,0,0,0)); exp_q.push_back(X(0,0,0,0,0,0));
        foreach (st[k]) begin
            apply(st[k]); #1;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL redirect_ext step %0d: got %b want %b", k, obs(), e); end
        end
    endtask

    task automatic test_drain();
        stim_t st[$];
        exp_t  e;
        st.push_back(S(1,0,0,3,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(1,0,0,4,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,1,0));
        st.push_back(S(0,0,0,0,0,0,0,0,1)); exp_q.push_back(X(0,0,0,0,1,0));
        st.push_back(S(1,3,0,0,0,1,3,0,1)); exp_q.push_back(X(1,0,0,0,1,2));
        st.push_back(S(0,0,0,0,0,1,4,0,1)); exp_q.push_back(X(1,0,0,1,1,2));
        st.push_back(S(0,0,0,0,0,0,0,0,0)); exp_q.push_back(X(1,0,0,1,0,2));
        st.push_back(S(0,0,0,0,0,0,0,0,0)); exp_q.push_back(X(0,0,0,0,0,0));
        foreach (st[k]) begin
            apply(st[k]); #1;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL drain step %0d: got %b want %b", k, obs(), e); end
        end
    endtask

    task automatic test_same_cycle();
        stim_t st[$];
        exp_t  e;
        st.push_back(S(1,0,0,9,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(1,0,0,9,1,1,9,0,0)); exp_q.push_back(X(0,1,0,0,1,0));
        st.push_back(S(1,0,9,0,0,0,0,0,0)); exp_q.push_back(X(1,0,0,0,1,0));
        st.push_back(S(1,0,9,0,0,1,9,0,0)); exp_q.push_back(X(0,1,0,0,1,0));
        st.push_back(S(1,0,9,0,0,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(0,0,0,0,0,0,0,0,0)); exp_q.push_back(X(0,0,0,0,0,0));
        foreach (st[k]) begin
            apply(st[k]); #1;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL same_cycle step %0d: got %b want %b", k, obs(), e); end
        end
    endtask

    task automatic test_mid_reset();
        stim_t st[$];
        exp_t  e;
        st.push_back(S(1,0,0,5,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,0,0));
        st.push_back(S(1,0,0,5,1,0,0,0,0)); exp_q.push_back(X(0,1,0,0,1,0));
        st.push_back(S(0,0,0,0,0,0,0,0,1)); exp_q.push_back(X(0,0,0,0,1,0));
        st.push_back(S(1,5,0,0,0,0,0,0,1)); exp_q.push_back(X(1,0,0,0,1,2));
        foreach (st[k]) begin
            apply(st[k]); #1;
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) begin failures++; $display("FAIL mid_reset step %0d: got %b want %b", k, obs(), e); end
        end
        #1 i_rst = 1'b1; i_redirect = 1'b1;
        exp_q.push_back(X(0,0,0,0,0,0)); #1;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL mid_reset_async: got %b want %b", obs(), e); end
        @(negedge i_clk); exp_q.push_back(X(0,0,0,0,0,0)); #1;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL mid_reset_held: got %b want %b", obs(), e); end
        apply(S(1,5,0,0,0,0,0,0,0)); i_rst = 1'b0; exp_q.push_back(X(0,1,0,0,0,0)); #1;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) begin failures++; $display("FAIL mid_reset_release: got %b want %b", obs(), e); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_id_valid = 1'b0; i_rs1_raddr = '0; i_rs2_raddr = '0; i_rd = '0;
        i_reg_write = 1'b0; i_wb_valid = 1'b0; i_wb_waddr = '0;
        i_redirect = 1'b0; i_drain_req = 1'b0;
        test_reset();
        test_raw();
        test_x0_saturation();
        test_redirect();
        test_redirect_extend();
        test_drain();
        test_same_cycle();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
